// File: rtl/mbr_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : mbr_pkg                                                  |
// | Description : Items shared by the frame-marker generator and the       |
// |               receive-side synchroniser: the default marker period and |
// |               the lock-state encoding.                                 |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
package mbr_pkg;

  // i320 rising edges between consecutive markers. The generator uses the
  // same constant so both ends of the link agree on the period.
  localparam int c_PERIOD_DEF = 40;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } mbr_state_t;

endpackage : mbr_pkg
`default_nettype wire

// File: rtl/mbr_sync_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface   : mbr_sync_if                                              |
// | Description : Marker link bundle between the connector side (i320,     |
// |               iMBR) and the frame-synchroniser outputs.                |
// | Ports       : i320   - bit-rate clock from transmitter (async)         |
// |               iMBR   - frame marker, active-low (async)                |
// |               oLock  - synchroniser locked                             |
// |               oFrame - one-clk pulse per accepted frame boundary       |
// |               oSlot  - slot index 0..PERIOD-1, valid while oLock       |
// |               oErr   - one-clk pulse per marker error while locked     |
// |   master : drives the link inputs, observes the outputs               |
// |   slave  : the synchroniser itself                                     |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
interface mbr_sync_if
  import mbr_pkg::*;
#(
  parameter int PERIOD = c_PERIOD_DEF
) ();

  localparam int CW = $clog2(PERIOD);

  logic          i320;
  logic          iMBR;
  logic          oLock;
  logic          oFrame;
  logic [CW-1:0] oSlot;
  logic          oErr;

  modport master (
    output i320, iMBR,
    input  oLock, oFrame, oSlot, oErr
  );

  modport slave (
    input  i320, iMBR,
    output oLock, oFrame, oSlot, oErr
  );

endinterface : mbr_sync_if
`default_nettype wire

// File: rtl/mbr_sync_in.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mbr_sync_in                                              |
// | Description : Brings an asynchronous strobe/data pair into the clk     |
// |               domain. The strobe gets a 2-flop synchroniser plus a     |
// |               third flop for rising-edge detection; the active-low     |
// |               data line gets a matching 2-flop synchroniser so it is   |
// |               sampled on the same synchronised edge.                   |
// | Ports       : clk      - system clock                                  |
// |               rst      - asynchronous reset, active-low                |
// |               i_edge   - asynchronous strobe (rising edge = event)     |
// |               i_mark_n - asynchronous active-low data                  |
// |               o_tick   - one-clk pulse per strobe rising edge          |
// |               o_mk     - o_tick qualified by i_mark_n low              |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module mbr_sync_in (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_edge,
  input  wire logic i_mark_n,
  output logic      o_tick,
  output logic      o_mk
);

  // [0]=s1, [1]=s2, [2]=s3 (edge-detect history)
  logic [2:0] r_edge_sync;
  logic [1:0] r_mark_sync;

  // Reset to the idle-high level of both lines so that releasing reset
  // cannot manufacture a tick or a marker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_edge_sync <= '1;
      r_mark_sync <= '1;
    end else begin
      r_edge_sync <= {r_edge_sync[1:0], i_edge};
      r_mark_sync <= {r_mark_sync[0], i_mark_n};
    end
  end

  assign o_tick = r_edge_sync[1] & ~r_edge_sync[2];
  assign o_mk   = o_tick & ~r_mark_sync[1];

endmodule : mbr_sync_in
`default_nettype wire

// File: rtl/mbr_sync.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mbr_sync                                                 |
// | Description : Receive-side frame-marker synchroniser. Hunts for the    |
// |               active-low marker on the i320 stream, verifies LOCK_CNT  |
// |               correctly spaced markers, then flywheels a slot counter  |
// |               and reports frame boundaries and marker errors. MISS_MAX |
// |               consecutive errors drop lock.                            |
// | Ports       : clk  - system clock (>= 4x i320 rate)                    |
// |               rst  - asynchronous reset, active-low                    |
// |               bus  - mbr_sync_if.slave (i320/iMBR in; oLock, oFrame,   |
// |                      oSlot, oErr out, all registered)                  |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module mbr_sync
  import mbr_pkg::*;
#(
  parameter int PERIOD   = c_PERIOD_DEF,
  parameter int LOCK_CNT = 3,
  parameter int MISS_MAX = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  mbr_sync_if.slave bus
);

  localparam int CW = $clog2(PERIOD);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(MISS_MAX + 1);

  localparam logic [CW-1:0] c_PHASE_LAST = CW'(PERIOD - 1);
  localparam logic [GW-1:0] c_GOOD_LOCK  = GW'(LOCK_CNT);
  localparam logic [MW-1:0] c_MISS_LAST  = MW'(MISS_MAX);

  logic          w_tick;
  logic          w_mk;
  logic          w_exp;
  logic          w_realign;
  logic [CW-1:0] w_phase_nxt;
  logic [GW-1:0] w_good_inc;
  logic [MW-1:0] w_miss_inc;

  mbr_state_t    r_state;
  logic [CW-1:0] r_phase;
  logic [GW-1:0] r_good;
  logic [MW-1:0] r_miss;
  logic          r_lock;
  logic          r_frame;
  logic          r_err;

  mbr_sync_in u_in (
    .clk      (clk),
    .rst      (rst),
    .i_edge   (bus.i320),
    .i_mark_n (bus.iMBR),
    .o_tick   (w_tick),
    .o_mk     (w_mk)
  );

  assign w_exp      = w_tick & (r_phase == c_PHASE_LAST);
  assign w_good_inc = r_good + 1'b1;
  assign w_miss_inc = r_miss + 1'b1;

  // Any marker outside LOCKED restarts the phase. While locked the counter
  // flywheels: an accepted marker lands on the natural wrap anyway, and a
  // misplaced one must not pull the phase.
  assign w_realign = w_mk & (r_state != ST_LOCKED);

  always_comb begin
    w_phase_nxt = r_phase;
    if (w_tick) begin
      if (w_realign || (r_phase == c_PHASE_LAST)) begin
        w_phase_nxt = '0;
      end else begin
        w_phase_nxt = r_phase + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_HUNT;
      r_phase <= '0;
      r_good  <= '0;
      r_miss  <= '0;
      r_lock  <= 1'b0;
      r_frame <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      r_err   <= 1'b0;
      r_phase <= w_phase_nxt;
      if (w_tick) begin
        case (r_state)
          ST_HUNT: begin
            if (w_mk) begin
              r_good  <= GW'(1);
              r_state <= ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            if (w_exp && w_mk) begin
              r_good <= w_good_inc;
              if (w_good_inc == c_GOOD_LOCK) begin
                r_state <= ST_LOCKED;
                r_miss  <= '0;
                r_lock  <= 1'b1;
                r_frame <= 1'b1;
              end
            end else if (w_exp) begin
              r_state <= ST_HUNT;
              r_good  <= '0;
            end else if (w_mk) begin
              // early marker becomes the new candidate
              r_good <= GW'(1);
            end
          end
          ST_LOCKED: begin
            if (w_exp && w_mk) begin
              r_frame <= 1'b1;
              r_miss  <= '0;
            end else if (w_exp || w_mk) begin
              r_err <= 1'b1;
              if (w_miss_inc == c_MISS_LAST) begin
                r_state <= ST_HUNT;
                r_lock  <= 1'b0;
                r_good  <= '0;
                r_miss  <= '0;
              end else begin
                r_miss <= w_miss_inc;
              end
            end
          end
          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

  assign bus.oLock  = r_lock;
  assign bus.oFrame = r_frame;
  assign bus.oErr   = r_err;
  assign bus.oSlot  = r_phase;

endmodule : mbr_sync
`default_nettype wire

// File: tb/tb_mbr_sync.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_mbr_sync                                              |
// | Description : Randomised bench for mbr_sync. i320 runs at clk/8; each  |
// |               issued tick updates a tick-index reference model and     |
// |               queues any expected oFrame/oErr event; a monitor pops    |
// |               and compares whenever the DUT pulses.                    |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_mbr_sync;

  localparam int PER  = 40;
  localparam int LCK  = 3;
  localparam int MMAX = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mbr_sync_if #(.PERIOD(PER)) bus ();

  mbr_sync #(.PERIOD(PER), .LOCK_CNT(LCK), .MISS_MAX(MMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        frame;
    logic        err;
    logic        lock;
    logic [31:0] slot;
    logic [31:0] tick;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  // Reference model: tick-indexed. anchor is the tick index at which slot 0
  // was last established; slot of tick t is (t - anchor) mod PER.
  int tcnt     = 0;
  int m_mode   = 0;   // 0 hunt, 1 verify, 2 locked
  int m_good   = 0;
  int m_miss   = 0;
  int m_anchor = 0;
  int mpos     = PER - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_tick(input bit mark);
    bit ex, ev_f, ev_e;
    ev_t e;
    ex   = ((tcnt - m_anchor) % PER) == 0;
    ev_f = 1'b0;
    ev_e = 1'b0;
    case (m_mode)
      0: if (mark) begin m_anchor = tcnt; m_mode = 1; m_good = 1; end
      1: begin
        if (ex && mark) begin
          m_good++;
          m_anchor = tcnt;
          if (m_good == LCK) begin m_mode = 2; m_miss = 0; ev_f = 1'b1; end
        end else if (ex) begin
          m_mode = 0; m_good = 0;
        end else if (mark) begin
          m_anchor = tcnt; m_good = 1;
        end
      end
      default: begin
        if (ex && mark) begin
          ev_f = 1'b1; m_miss = 0; m_anchor = tcnt;
        end else if (ex != mark) begin
          ev_e = 1'b1;
          m_miss++;
          if (m_miss == MMAX) begin m_mode = 0; m_good = 0; m_miss = 0; end
        end
      end
    endcase
    if (ev_f || ev_e) begin
      e.frame = ev_f;
      e.err   = ev_e;
      e.lock  = (m_mode == 2);
      e.slot  = (tcnt - m_anchor) % PER;
      e.tick  = tcnt;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_tick(input bit mark);
    bus.iMBR = ~mark;
    repeat (4) @(posedge clk);
    #2;
    bus.i320 = 1'b1;
    tcnt++;
    model_tick(mark);
    repeat (4) @(posedge clk);
    #2;
    check("lock", bus.oLock, (m_mode == 2));
    if (m_mode == 2) check("slot", bus.oSlot, (tcnt - m_anchor) % PER);
    bus.i320 = 1'b0;
  endtask

  // kind: 0 normal, 1 drop, 2 shift by arg, 3 doubled marker,
  //       4 marker stuck low, 5 sparse random noise
  task automatic do_frame(input int kind, input int arg);
    bit marks [PER];
    for (int i = 0; i < PER; i++) marks[i] = 1'b0;
    case (kind)
      0: marks[mpos] = 1'b1;
      1: ;
      2: begin mpos = (mpos + arg) % PER; marks[mpos] = 1'b1; end
      3: begin marks[mpos] = 1'b1; marks[(mpos + 1) % PER] = 1'b1; end
      4: for (int i = 0; i < PER; i++) marks[i] = 1'b1;
      default: for (int i = 0; i < PER; i++) marks[i] = ($urandom_range(0, 19) == 0);
    endcase
    for (int i = 0; i < PER; i++) do_tick(marks[i]);
  endtask

  task automatic frames(input int kind, input int n);
    for (int i = 0; i < n; i++) do_frame(kind, 0);
  endtask

  // Monitor: every output pulse consumes one expected event.
  always @(negedge clk) begin
    ev_t e;
    if (rst && (bus.oFrame === 1'b1 || bus.oErr === 1'b1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: frame=%0b err=%0b tick=%0d, no event expected",
                 bus.oFrame, bus.oErr, tcnt);
      end else begin
        e = exp_q.pop_front();
        check("ev_frame", bus.oFrame, e.frame);
        check("ev_err",   bus.oErr,   e.err);
        check("ev_lock",  bus.oLock,  e.lock);
        check("ev_slot",  bus.oSlot,  e.slot);
        check("ev_tick",  tcnt,       e.tick);
      end
    end
  end

  initial begin
    bus.i320 = 1'b1;
    bus.iMBR = 1'b1;
    rst      = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_lock",  bus.oLock,  0);
    check("rst_frame", bus.oFrame, 0);
    check("rst_err",   bus.oErr,   0);
    check("rst_slot",  bus.oSlot,  0);
    rst = 1'b1;

    // idle with both lines high: nothing may happen
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_lock",  bus.oLock,  0);
      check("idle_err",   bus.oErr,   0);
      check("idle_frame", bus.oFrame, 0);
    end
    bus.i320 = 1'b0;
    repeat (8) @(posedge clk);
    #2;

    frames(0, 5);                 // acquire and run locked
    frames(1, 1); frames(0, 2);   // single drop
    frames(1, 2); frames(0, 5);   // double drop -> hunt -> relock
    do_frame(2, 5); frames(0, 5); // shifted phase -> relock at new phase

    // asynchronous reset mid-frame while locked
    frames(0, 1);
    for (int i = 0; i < 17; i++) do_tick(1'b0);
    check("prerst_queue", exp_q.size(), 0);
    #1;
    rst = 1'b0;
    #1;
    check("arst_lock",  bus.oLock,  0);
    check("arst_frame", bus.oFrame, 0);
    check("arst_err",   bus.oErr,   0);
    check("arst_slot",  bus.oSlot,  0);
    m_mode   = 0;
    m_good   = 0;
    m_miss   = 0;
    m_anchor = tcnt;
    @(posedge clk);
    #2;
    rst = 1'b1;
    frames(0, 4);

    // marker stuck low while locked, then recovery
    frames(4, 1); frames(0, 5);

    // i320 stopped with the marker line low: everything frozen
    bus.iMBR = 1'b0;
    repeat (200) @(posedge clk);
    #2;
    check("stop_lock", bus.oLock, (m_mode == 2));
    bus.iMBR = 1'b1;

    // randomised frame mix
    for (int f = 0; f < 30; f++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5)      do_frame(0, 0);
      else if (r == 6) do_frame(1, 0);
      else if (r == 7) do_frame(2, $urandom_range(1, PER - 1));
      else if (r == 8) do_frame(3, 0);
      else             do_frame(5, 0);
    end
    frames(0, 4);

    repeat (10) @(posedge clk);
    #2;
    check("queue_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mbr_sync
`default_nettype wire

// File: doc/mbr_sync.md
Name: mbr_sync

Overview:
Receive-side counterpart of the frame-marker generator. It watches the 320-rate bit clock (i320) and the active-low frame marker line (iMBR), finds the marker period, and declares lock after repeated correct markers. It then supplies a slot index, a frame strobe and error/loss indication to the downstream telemetry deframer. It sits at the input of the receiving board, directly behind the connector.

Parameters:
PERIOD, 40, i320 rising edges between consecutive markers (marker occupies one slot).
LOCK_CNT, 3, consecutive correctly spaced markers needed in VERIFY to enter LOCKED.
MISS_MAX, 2, consecutive marker errors in LOCKED that force return to HUNT.
CW (localparam), $clog2(PERIOD), slot counter width (6 for default).

Ports:
clk  input  1  system clock; must be at least 4x the i320 rate.
rst  input  1  asynchronous reset, active-low.
i320  input  1  bit-rate clock from transmitter, asynchronous to clk.
iMBR  input  1  frame marker, active-low, asynchronous to clk.
oLock  output  1  high while in LOCKED.
oFrame  output  1  one-clk pulse at each accepted frame boundary while locked.
oSlot  output  CW  current slot index 0..PERIOD-1. Valid only when oLock=1.
oErr  output  1  one-clk pulse per marker error (missing or misplaced marker) in LOCKED.

Behaviour:
- Reset (async, rst=0):
  - state=HUNT; phase=0; good=0; miss=0.
  - oLock=0, oFrame=0, oErr=0, oSlot=0.
  - i320 synchroniser flops = 1 and iMBR synchroniser flops = 1, so there is no false tick or marker at reset release.
- Input conditioning:
  - i320 and iMBR each pass through a 2-flop synchroniser; i320 has a third flop for edge detection.
  - tick = (i320_s2 & ~i320_s3).
  - mk = tick & ~iMBR_s2, i.e. the marker is sampled on the same synchronised edge.
  - All state changes occur only in tick cycles. Non-tick cycles hold everything except the pulse outputs, which clear.
- Phase counter:
  - On marker acceptance, phase<=0.
  - Otherwise, on every tick, phase<=phase+1, wrapping PERIOD-1 -> 0.
  - exp = tick & (phase==PERIOD-1).
  - oSlot<=phase next value (registered).
- FSM states: HUNT, VERIFY, LOCKED.
  - HUNT:
    - mk -> phase<=0, good<=1, go VERIFY.
    - Otherwise phase free-runs; oSlot is not meaningful.
  - VERIFY:
    - exp & mk -> good<=good+1. If good+1==LOCK_CNT, go LOCKED with miss<=0 and assert oFrame that tick.
    - exp & ~mk (missing marker) -> HUNT, good<=0.
    - mk & ~exp (early marker) -> stay VERIFY, treat as new candidate: phase<=0, good<=1.
  - LOCKED:
    - exp & mk -> oFrame<=1, miss<=0.
    - exp & ~mk, or mk & ~exp -> oErr<=1, miss<=miss+1, phase keeps free-running (flywheel, no realign).
    - If miss+1==MISS_MAX -> HUNT, oLock<=0 on that same edge, good<=0.
- oLock is registered; it goes to 1 on the edge that enters LOCKED and to 0 on the edge that leaves it.
- Latency:
  - i320 rising at the pin -> tick: 2 clk edges (third edge for the s3 compare).
  - tick -> oFrame/oErr/oSlot update: 1 further edge.
  - Total: pin edge to oFrame = 3 clk edges.
- Boundary conditions:
  - iMBR stuck low: every tick is mk. LOCKED -> errors on consecutive ticks -> HUNT after MISS_MAX ticks. VERIFY keeps restarting the candidate and never locks.
  - i320 stopped: no ticks, all state frozen, no errors. Loss of i320 is not detected here.
  - Marker low for 2 consecutive ticks: the second one counts as misplaced.
  - Reset asserted mid-frame: immediate return to reset values, independent of clk.

Decomposition:
- Shared package mbr_pkg holds:
  - state enum (HUNT/VERIFY/LOCKED);
  - default PERIOD=40, which the generator block also uses, so both ends share one constant.
- One natural sub-module: mbr_sync_in. It contains the 2/3-flop synchroniser plus edge detect, outputs tick and mk, and is reused for any other async strobe pair.
- Counter and FSM stay in the top module.

Test Plan:
1. Reset release with i320=1, iMBR=1 -> no tick, oLock=0, oErr=0 for 20 clk.
2. Ideal stream: i320 at clk/8, marker low in slot 39 of every 40. After the 3rd accepted marker (LOCK_CNT=3), oLock=1. Then one oFrame pulse every 320 clk; oSlot counts 0..39 in step with the stream.
3. Locked, then drop one marker -> single oErr pulse, oLock stays 1. Next marker correct -> miss clears, oFrame resumes.
4. Locked, then drop two consecutive markers -> two oErr pulses 320 clk apart, oLock falls on the second one. Relock after 3 further correct markers.
5. Markers shifted by 5 slots while LOCKED -> oErr on the misplaced marker and on the missing expected one -> HUNT. Relock at the new phase, with oSlot=0 on the tick after the new marker.
6. Assert rst for 1 clk mid-frame while locked -> all outputs 0 asynchronously. State returns to HUNT and lock is reacquired after 3 markers.
